// File: rtl/uart_mmio_responder.sv
// Memory-mapped 8N1 UART responder: TXD/RXD/CON registers at 0x40000018..0x40000020.
// Serialises TXD stores onto uart_tx and deserialises uart_rx into RXD.
module uart_mmio_responder #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t      tx_state;
    rx_state_t      rx_state;
    logic [7:0]     txd, rxd, tx_shift, rx_shift;
    logic           tx_en, rx_en;
    logic           tx_done, rx_ready, frame_err;
    logic           tx_busy;
    logic [CW-1:0]  tx_cnt, rx_cnt;
    logic [2:0]     tx_bit, rx_bit;
    logic           rx_s1, rx_s2, rx_prev;

    logic sel_txd, sel_rxd, sel_con;
    logic txd_wr, con_wr, con_rd;
    logic unused_wdata;

    assign sel_txd = (addr == ADDR_TXD);
    assign sel_rxd = (addr == ADDR_RXD);
    assign sel_con = (addr == ADDR_CON);
    assign txd_wr  = wr & sel_txd;
    assign con_wr  = wr & sel_con;
    assign con_rd  = rd & sel_con;
    assign tx_busy = (tx_state != TX_IDLE);
    assign unused_wdata = ^wdata[31:8];

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_txd)
                rdata = {24'b0, txd};
            else if (sel_rxd)
                rdata = {24'b0, rxd};
            else if (sel_con)
                rdata = {26'b0, frame_err, tx_busy, rx_ready, tx_done, rx_en, tx_en};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            txd   <= '0;
            tx_en <= 1'b1;
            rx_en <= 1'b1;
        end else begin
            if (txd_wr)
                txd <= wdata[7:0];
            if (con_wr)
                {rx_en, tx_en} <= wdata[1:0];
        end
    end

    // Frame data is snapshotted into tx_shift so TXD writes while busy cannot corrupt it.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_done  <= 1'b0;
        end else begin
            if (con_rd)
                tx_done <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    uart_tx <= 1'b1;
                    tx_cnt  <= '0;
                    tx_bit  <= '0;
                    if (txd_wr && tx_en) begin
                        tx_shift <= wdata[7:0];
                        uart_tx  <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BAUD_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        uart_tx  <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BAUD_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            uart_tx  <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BAUD_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_IDLE;
                        tx_done  <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Flag clears precede the FSM so a set on the same edge as a CON read wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rxd       <= '0;
            rx_ready  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (con_rd) begin
                rx_ready  <= 1'b0;
                frame_err <= 1'b0;
            end
            if (!rx_en) begin
                rx_state <= RX_IDLE;
                rx_cnt   <= '0;
                rx_bit   <= '0;
            end else begin
                case (rx_state)
                    RX_IDLE: begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        if (rx_prev && !rx_s2)
                            rx_state <= RX_START;
                    end
                    RX_START: begin
                        if (rx_cnt == BAUD_HALF) begin
                            rx_cnt   <= '0;
                            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (rx_cnt == BAUD_LAST) begin
                            rx_cnt   <= '0;
                            rx_shift <= {rx_s2, rx_shift[7:1]};
                            if (rx_bit == 3'd7)
                                rx_state <= RX_STOP;
                            else
                                rx_bit <= rx_bit + 3'd1;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (rx_cnt == BAUD_LAST) begin
                            rx_cnt   <= '0;
                            rx_state <= RX_IDLE;
                            if (rx_s2) begin
                                rxd      <= rx_shift;
                                rx_ready <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= rx_ready | tx_done;
    end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Directed bench for uart_mmio_responder at CLKS_PER_BIT=4: register map,
// TX framing, RX framing/errors and flag clear-vs-set ordering.
module tb_uart_mmio_responder;

    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [31:0] rdata;
    logic        uart_rx;
    logic        uart_tx;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    uart_mmio_responder #(.CLKS_PER_BIT(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wdata   (wdata),
        .rd      (rd),
        .wr      (wr),
        .rdata   (rdata),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        tick;
        wr    = 1'b0;
        addr  = '0;
    endtask

    task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        rd   = 1'b1;
        #1;
        check(tag, rdata, exp);
        tick;
        rd   = 1'b0;
        addr = '0;
    endtask

    // Drives one frame, 4 clocks per bit, and returns with the line idle high.
    task automatic send_rx(input logic [7:0] b, input logic stopb);
        uart_rx = 1'b0;
        repeat (4) tick;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (4) tick;
        end
        uart_rx = stopb;
        repeat (4) tick;
        uart_rx = 1'b1;
    endtask

    logic [9:0] frame;

    initial begin
        reset = 1'b1; addr = '0; wdata = '0; rd = 1'b0; wr = 1'b0; uart_rx = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
        tick;

        // Reset state and decode
        check("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
        check("rst_irq", {31'b0, irq}, 32'h0);
        bus_rd("rst_con", CON, 32'h03);
        bus_rd("rst_rxd", RXD, 32'h00);
        bus_rd("rst_txd", TXD, 32'h00);
        addr = CON;
        #1;
        check("rdata_rd_low", rdata, 32'h0);
        bus_rd("unmapped_rd", 32'h4000_0024, 32'h0);
        bus_wr(32'h4000_0019, 32'h5A);
        check("near_miss_no_tx", {31'b0, uart_tx}, 32'h1);
        bus_rd("near_miss_txd", TXD, 32'h00);

        // TX 0xA5, with a store of 0x11 while busy
        frame = {1'b1, 8'hA5, 1'b0};
        addr = TXD; wdata = 32'hA5; wr = 1'b1;
        tick;
        wr = 1'b0;
        for (int c = 0; c < 40; c++) begin
            check($sformatf("tx_a5_bit%0d_clk%0d", c / 4, c % 4), {31'b0, uart_tx}, {31'b0, frame[c / 4]});
            if (c == 5) begin
                addr = CON; rd = 1'b1;
                #1;
                check("con_busy", rdata, 32'h13);
            end
            if (c == 10) begin
                addr = TXD; wdata = 32'h11; wr = 1'b1;
            end
            tick;
            wr = 1'b0; rd = 1'b0;
        end
        check("irq_before_done", {31'b0, irq}, 32'h0);
        bus_rd("con_tx_done", CON, 32'h07);
        check("irq_tx_done", {31'b0, irq}, 32'h1);
        tick;
        check("irq_after_clear", {31'b0, irq}, 32'h0);
        bus_rd("txd_latched_busy", TXD, 32'h11);
        for (int c = 0; c < 44; c++) begin
            check($sformatf("no_second_frame_clk%0d", c), {31'b0, uart_tx}, 32'h1);
            tick;
        end

        // RX 0x3C
        send_rx(8'h3C, 1'b1);
        tick; tick;
        check("irq_rx_ready", {31'b0, irq}, 32'h1);
        bus_rd("rxd_3c", RXD, 32'h3C);
        bus_rd("con_rx_ready", CON, 32'h0B);
        bus_rd("con_rx_cleared", CON, 32'h03);
        check("irq_rx_cleared", {31'b0, irq}, 32'h0);

        // RX 0x55 with bad stop bit
        send_rx(8'h55, 1'b0);
        tick; tick;
        bus_rd("con_frame_err", CON, 32'h23);
        check("irq_frame_err", {31'b0, irq}, 32'h0);
        bus_rd("rxd_unchanged", RXD, 32'h3C);
        bus_rd("con_err_cleared", CON, 32'h03);

        // rx_ready set on the same edge as a CON read
        send_rx(8'h96, 1'b1);
        bus_rd("con_same_edge", CON, 32'h03);
        bus_rd("con_set_wins", CON, 32'h0B);
        bus_rd("rxd_96", RXD, 32'h96);

        // RX disabled: frame ignored
        bus_wr(CON, 32'h1);
        send_rx(8'h42, 1'b1);
        tick; tick;
        bus_rd("con_rx_disabled", CON, 32'h01);
        bus_rd("rxd_rx_disabled", RXD, 32'h96);
        bus_wr(CON, 32'h3);

        // TX disabled: store latched, no frame
        bus_wr(CON, 32'h2);
        bus_wr(TXD, 32'h5A);
        for (int c = 0; c < 8; c++) begin
            check($sformatf("tx_disabled_clk%0d", c), {31'b0, uart_tx}, 32'h1);
            tick;
        end
        bus_rd("con_tx_disabled", CON, 32'h02);
        bus_rd("txd_tx_disabled", TXD, 32'h5A);
        bus_wr(CON, 32'h3);

        // Reset mid-frame
        bus_wr(TXD, 32'hFF);
        repeat (2) tick;
        check("midframe_start_low", {31'b0, uart_tx}, 32'h0);
        reset = 1'b1;
        tick;
        check("midframe_reset_tx", {31'b0, uart_tx}, 32'h1);
        reset = 1'b0;
        tick;
        bus_rd("midframe_reset_con", CON, 32'h03);
        bus_rd("midframe_reset_txd", TXD, 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
